// File: rtl/controle_rodada_pkg.sv
// Shared types and widths for the guessing-round controller.
package controle_rodada_pkg;

    localparam int unsigned VAL_W         = 4;
    localparam int unsigned DIFF_W        = 5;
    localparam int unsigned MAX_TRIES_DEF = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        CHECK = 3'd2,
        WON   = 3'd3,
        LOST  = 3'd4
    } state_t;

endpackage

// File: rtl/controle_rodada_subtrator.sv
// 5-bit two's-complement subtractor: y = a - b, purely combinational.
module subtrator_5b
    import controle_rodada_pkg::*;
(
    input  logic [DIFF_W-1:0] a,
    input  logic [DIFF_W-1:0] b,
    output logic [DIFF_W-1:0] y
);

    assign y = a - b;

endmodule

// File: rtl/controle_rodada.sv
// Round controller: captures a secret, judges guesses via an external comparator,
// and tracks attempts and the won/lost outcome.
module controle_rodada
    import controle_rodada_pkg::*;
#(
    parameter int unsigned MAX_TRIES = MAX_TRIES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VAL_W-1:0] secret,
    input  logic             load_secret,
    input  logic [VAL_W-1:0] guess,
    input  logic             guess_valid,
    input  logic             igual,
    input  logic             ate3,
    input  logic             errada,
    output logic [VAL_W-1:0] diff,
    output logic             sinal,
    output logic             diff_valid,
    output logic [2:0]       attempts,
    output logic             won,
    output logic             lost,
    output logic             proto_err
);

    state_t              state_q;
    state_t              state_d;
    logic [VAL_W-1:0]    secret_q;
    logic [VAL_W-1:0]    secret_d;
    logic [DIFF_W-1:0]   res_d;
    logic [DIFF_W-1:0]   sub_y;
    logic [2:0]          attempts_d;
    logic                proto_err_d;
    logic                diff_valid_d;
    logic                won_d;
    logic                lost_d;
    logic [1:0]          verdict_cnt;

    subtrator_5b u_sub (
        .a ({1'b0, guess}),
        .b ({1'b0, secret_q}),
        .y (sub_y)
    );

    assign verdict_cnt = 2'(igual) + 2'(ate3) + 2'(errada);

    // Next-state and next-output logic; load_secret overrides everything below it.
    always_comb begin
        state_d      = state_q;
        secret_d     = secret_q;
        res_d        = {sinal, diff};
        attempts_d   = attempts;
        proto_err_d  = proto_err;

        case (state_q)
            IDLE: ;
            ARMED: begin
                if (guess_valid) begin
                    res_d   = sub_y;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (verdict_cnt != 2'd1) begin
                    proto_err_d = 1'b1;
                end
                attempts_d = attempts + 3'd1;
                if (igual) begin
                    state_d = WON;
                end else if (attempts_d == 3'(MAX_TRIES)) begin
                    state_d = LOST;
                end else begin
                    state_d = ARMED;
                end
            end
            WON, LOST: ;
            default: state_d = IDLE;
        endcase

        if (load_secret) begin
            secret_d   = secret;
            attempts_d = '0;
            res_d      = {sinal, diff};
            state_d    = ARMED;
        end

        diff_valid_d = (state_d == CHECK);
        won_d        = (state_d == WON);
        lost_d       = (state_d == LOST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            secret_q    <= '0;
            diff        <= '0;
            sinal       <= 1'b0;
            diff_valid  <= 1'b0;
            attempts    <= '0;
            won         <= 1'b0;
            lost        <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            secret_q    <= secret_d;
            {sinal, diff} <= res_d;
            diff_valid  <= diff_valid_d;
            attempts    <= attempts_d;
            won         <= won_d;
            lost        <= lost_d;
            proto_err   <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_controle_rodada.sv
// Bench for controle_rodada: vector table, scoreboard on diff_valid, corner sequences.
module tb_controle_rodada;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] secret;
    logic       load_secret;
    logic [3:0] guess;
    logic       guess_valid;
    logic       igual;
    logic       ate3;
    logic       errada;
    logic [3:0] diff;
    logic       sinal;
    logic       diff_valid;
    logic [2:0] attempts;
    logic       won;
    logic       lost;
    logic       proto_err;

    logic       force_bad;
    int         total = 0;
    int         bad   = 0;
    logic [4:0] sb[$];

    typedef struct {
        logic [3:0] sec;
        logic [3:0] gs;
        logic [4:0] res;
        logic       win;
        logic       near;
    } vec_t;

    vec_t tbl[7];

    controle_rodada dut (
        .clk         (clk),
        .reset       (reset),
        .secret      (secret),
        .load_secret (load_secret),
        .guess       (guess),
        .guess_valid (guess_valid),
        .igual       (igual),
        .ate3        (ate3),
        .errada      (errada),
        .diff        (diff),
        .sinal       (sinal),
        .diff_valid  (diff_valid),
        .attempts    (attempts),
        .won         (won),
        .lost        (lost),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    // Reference comparator: equal / within 3 / further away.
    always_comb begin
        logic signed [4:0] v;
        int mag;
        v   = $signed({sinal, diff});
        mag = (v < 0) ? -int'(v) : int'(v);
        if (force_bad) begin
            igual  = 1'b1;
            ate3   = 1'b1;
            errada = 1'b0;
        end else begin
            igual  = (mag == 0);
            ate3   = (mag != 0) && (mag <= 3);
            errada = (mag > 3);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (diff_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_diff_valid", 32'(diff_valid), 32'd0);
            end else begin
                chk("diff_sinal", 32'({sinal, diff}), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] s);
        secret      = s;
        load_secret = 1'b1;
        tick();
        load_secret = 1'b0;
    endtask

    task automatic do_guess(input logic [3:0] g, input logic [4:0] exp);
        guess       = g;
        guess_valid = 1'b1;
        sb.push_back(exp);
        tick();
        guess_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk(name, 32'({diff, sinal, diff_valid, attempts, won, lost, proto_err}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; secret = '0; load_secret = 1'b0;
        guess = '0; guess_valid = 1'b0; force_bad = 1'b0;

        tbl[0] = '{4'd9,  4'd9,  5'b00000, 1'b1, 1'b0};
        tbl[1] = '{4'd9,  4'd7,  5'b11110, 1'b0, 1'b1};
        tbl[2] = '{4'd9,  4'd12, 5'b00011, 1'b0, 1'b1};
        tbl[3] = '{4'd0,  4'd15, 5'b01111, 1'b0, 1'b0};
        tbl[4] = '{4'd15, 4'd0,  5'b10001, 1'b0, 1'b0};
        tbl[5] = '{4'd3,  4'd3,  5'b00000, 1'b1, 1'b0};
        tbl[6] = '{4'd8,  4'd2,  5'b11010, 1'b0, 1'b0};

        tick(); tick();
        reset = 1'b0;
        chk_zero("reset_state");

        // Guesses in IDLE are ignored.
        guess = 4'd3; guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        chk("idle_ignore_dv", 32'(diff_valid), 32'd0);
        tick();
        chk_zero("idle_ignore_state");

        for (int i = 0; i < 7; i++) begin
            do_load(tbl[i].sec);
            chk("vec_attempts_clear", 32'(attempts), 32'd0);
            do_guess(tbl[i].gs, tbl[i].res);
            chk("vec_dv", 32'(diff_valid), 32'd1);
            chk("vec_ate3", 32'(ate3), 32'(tbl[i].near));
            chk("vec_errada", 32'(errada), 32'(!tbl[i].win && !tbl[i].near));
            tick();
            chk("vec_won", 32'(won), 32'(tbl[i].win));
            chk("vec_lost", 32'(lost), 32'd0);
            chk("vec_attempts", 32'(attempts), 32'd1);
            chk("vec_dv_low", 32'(diff_valid), 32'd0);
        end

        // Seven misses lose the round; an eighth guess is ignored.
        do_load(4'd5);
        for (int i = 0; i < 7; i++) begin
            do_guess(4'd0, 5'b11011);
            tick();
            chk("lose_attempts", 32'(attempts), 32'(i + 1));
            chk("lose_flag", 32'(lost), 32'(i == 6));
        end
        chk("lose_won", 32'(won), 32'd0);
        guess = 4'd5; guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        chk("lost_ignore_dv", 32'(diff_valid), 32'd0);
        tick();
        chk("lost_hold", 32'({lost, won, attempts}), 32'({1'b1, 1'b0, 3'd7}));

        // load_secret wins over a simultaneous guess.
        do_load(4'd4);
        secret = 4'd4; load_secret = 1'b1; guess = 4'd4; guess_valid = 1'b1;
        tick();
        load_secret = 1'b0; guess_valid = 1'b0;
        chk("prio_dv", 32'(diff_valid), 32'd0);
        chk("prio_diff_hold", 32'({sinal, diff}), 32'(5'b11011));
        tick();
        chk("prio_state", 32'({won, lost, attempts}), 32'd0);
        do_guess(4'd4, 5'b00000);
        tick();
        chk("prio_armed", 32'({won, attempts}), 32'({1'b1, 3'd1}));

        // load_secret during CHECK discards the pending verdict.
        do_load(4'd4);
        do_guess(4'd4, 5'b00000);
        secret = 4'd6; load_secret = 1'b1;
        tick();
        load_secret = 1'b0;
        chk("chk_load", 32'({won, lost, diff_valid, attempts}), 32'd0);
        do_guess(4'd6, 5'b00000);
        tick();
        chk("chk_load_next", 32'({won, attempts}), 32'({1'b1, 3'd1}));

        // Reset during CHECK.
        do_load(4'd2);
        do_guess(4'd5, 5'b00011);
        secret = 4'd1; load_secret = 1'b1; guess_valid = 1'b1;
        do_reset();
        load_secret = 1'b0; guess_valid = 1'b0;
        chk_zero("reset_in_check");

        // Non-one-hot verdict sets a sticky protocol error.
        do_load(4'd1);
        force_bad = 1'b1;
        do_guess(4'd1, 5'b00000);
        tick();
        force_bad = 1'b0;
        chk("proto_set", 32'(proto_err), 32'd1);
        do_load(4'd3);
        tick();
        chk("proto_sticky", 32'(proto_err), 32'd1);
        do_reset();
        chk("proto_clear", 32'(proto_err), 32'd0);

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
